// File: rtl/hpdl1414_scan_pkg.sv
// Shared types and character mapping for the HPDL1414 scan engine.
// Maps buffer bytes onto the display's 64-glyph set (0x20..0x5F).
package hpdl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_SETUP,
    S_PULSE,
    S_HOLD
  } scan_state_t;

  localparam logic [6:0] CHAR_SPACE        = 7'h20;
  localparam int         CHARS_PER_DISPLAY = 4;

  // Lowercase folds onto uppercase; control and high-half bytes render as blanks.
  function automatic logic [6:0] map_char(input logic [7:0] c);
    logic [6:0] r;
    r = CHAR_SPACE;
    if (c >= 8'h20 && c <= 8'h5F) begin
      r = c[6:0];
    end else if (c >= 8'h60 && c <= 8'h7F) begin
      r = c[6:0] - 7'h20;
    end
    return r;
  endfunction

endpackage

// File: rtl/hpdl1414_scan_tick_gen.sv
// Free-running refresh divider; o_tick is high for the last count of each period.
// One tick every DIV cycles, first tick DIV-1 cycles after reset release.
module tick_gen #(
  parameter int DIV = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign o_tick = w_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hpdl1414_scan.sv
// Scans the 16-byte character buffer into chained HPDL1414 displays once per refresh tick.
// Each character takes 2 + SETUP + PULSE + HOLD cycles; all outputs are registered.
module hpdl1414_scan
  import hpdl_pkg::*;
#(
  parameter int NUM_DISPLAYS = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1,
  parameter int REFRESH_DIV  = 1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  output logic                    o_read_enable,
  output logic [3:0]              o_read_address,
  input  logic [7:0]              i_read_data,
  output logic [6:0]              o_data,
  output logic [1:0]              o_addr,
  output logic [NUM_DISPLAYS-1:0] o_wr_n,
  output logic                    o_frame_done
);

  localparam int NCHARS  = CHARS_PER_DISPLAY * NUM_DISPLAYS;
  localparam int PH_MAX0 = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int PH_MAX  = (PH_MAX0 > HOLD_CYCLES) ? PH_MAX0 : HOLD_CYCLES;
  localparam int PW      = $clog2(PH_MAX + 1);

  localparam logic [3:0]    IDX_LAST   = 4'(NCHARS - 1);
  localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(HOLD_CYCLES - 1);

  scan_state_t             r_state, w_state_nxt;
  logic [3:0]              r_idx, w_idx_nxt;
  logic [PW-1:0]           r_phase, w_phase_nxt;
  logic                    w_tick;
  logic                    w_frame_end;
  logic [NUM_DISPLAYS-1:0] w_wr_n_nxt;

  tick_gen #(.DIV(REFRESH_DIV)) u_tick_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_phase_nxt = r_phase + PW'(1);
    w_frame_end = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_phase_nxt = '0;
        if (w_tick && i_enable) begin
          w_state_nxt = S_FETCH;
          w_idx_nxt   = '0;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_LATCH;
        w_phase_nxt = '0;
      end
      S_LATCH: begin
        w_state_nxt = S_SETUP;
        w_phase_nxt = '0;
      end
      S_SETUP: begin
        if (r_phase == SETUP_LAST) begin
          w_state_nxt = S_PULSE;
          w_phase_nxt = '0;
        end
      end
      S_PULSE: begin
        if (r_phase == PULSE_LAST) begin
          w_state_nxt = S_HOLD;
          w_phase_nxt = '0;
        end
      end
      S_HOLD: begin
        if (r_phase == HOLD_LAST) begin
          w_phase_nxt = '0;
          // Enable is only sampled here so a started character always finishes cleanly.
          if (r_idx == IDX_LAST || !i_enable) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            w_frame_end = (r_idx == IDX_LAST);
          end else begin
            w_state_nxt = S_FETCH;
            w_idx_nxt   = r_idx + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
        w_phase_nxt = '0;
      end
    endcase
    for (int k = 0; k < NUM_DISPLAYS; k++) begin
      w_wr_n_nxt[k] = !((w_state_nxt == S_PULSE) && (r_idx[3:2] == 2'(k)));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_n         <= '1;
      o_read_enable  <= 1'b0;
      o_read_address <= '0;
      o_data         <= CHAR_SPACE;
      o_addr         <= '0;
      o_frame_done   <= 1'b0;
    end else begin
      o_wr_n        <= w_wr_n_nxt;
      o_read_enable <= (w_state_nxt == S_FETCH);
      o_frame_done  <= w_frame_end;
      if (w_state_nxt == S_FETCH) begin
        o_read_address <= w_idx_nxt;
      end
      if (r_state == S_LATCH) begin
        o_data <= map_char(i_read_data);
        o_addr <= 2'd3 - r_idx[1:0];
      end
    end
  end

endmodule

// File: tb/tb_hpdl1414_scan.sv
// Bench for hpdl1414_scan: per-cycle traces are reduced to a list of display writes
// and compared with the write list expected from the buffer contents.
module tb_hpdl1414_scan;

  localparam int DIV_A = 200;
  localparam int DIV_B = 100;

  typedef struct {int wr; int data; int addr; int re; int ra; int fd;} smp_t;
  typedef struct {int disp; int addr; int data; int plen; int setup_ok; int hold_ok;} wr_t;

  logic       clk = 1'b0;
  logic       rst_a_n, rst_b_n, en_a, en_b;
  logic       re_a, re_b, fd_a, fd_b;
  logic [3:0] ra_a, ra_b;
  logic [7:0] rd_a, rd_b;
  logic [6:0] d_a, d_b;
  logic [1:0] ad_a, ad_b;
  logic [3:0] wr_a;
  logic [0:0] wr_b;

  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];

  smp_t tr_a[$], tr_b[$], tr[$];
  wr_t  wrs[$];
  smp_t sa, sb;
  bit   rec_a = 1'b0, rec_b = 1'b0;
  int   n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  hpdl1414_scan #(.NUM_DISPLAYS(4), .SETUP_CYCLES(1), .PULSE_CYCLES(2),
                  .HOLD_CYCLES(1), .REFRESH_DIV(DIV_A)) dut_a (
    .i_clk(clk), .i_rst_n(rst_a_n), .i_enable(en_a),
    .o_read_enable(re_a), .o_read_address(ra_a), .i_read_data(rd_a),
    .o_data(d_a), .o_addr(ad_a), .o_wr_n(wr_a), .o_frame_done(fd_a));

  hpdl1414_scan #(.NUM_DISPLAYS(1), .SETUP_CYCLES(2), .PULSE_CYCLES(3),
                  .HOLD_CYCLES(2), .REFRESH_DIV(DIV_B)) dut_b (
    .i_clk(clk), .i_rst_n(rst_b_n), .i_enable(en_b),
    .o_read_enable(re_b), .o_read_address(ra_b), .i_read_data(rd_b),
    .o_data(d_b), .o_addr(ad_b), .o_wr_n(wr_b), .o_frame_done(fd_b));

  // Character buffers with a registered read port.
  always @(posedge clk) begin
    if (re_a) rd_a <= mem_a[ra_a];
    if (re_b) rd_b <= mem_b[ra_b];
  end

  always @(negedge clk) begin
    if (rec_a) begin
      sa.wr = int'(wr_a); sa.data = int'(d_a); sa.addr = int'(ad_a);
      sa.re = int'(re_a); sa.ra = int'(ra_a); sa.fd = int'(fd_a);
      tr_a.push_back(sa);
    end
    if (rec_b) begin
      sb.wr = int'(wr_b); sb.data = int'(d_b); sb.addr = int'(ad_b);
      sb.re = int'(re_b); sb.ra = int'(ra_b); sb.fd = int'(fd_b);
      tr_b.push_back(sb);
    end
  end

  function automatic int ref_map(input int b);
    if (b < 32 || b > 127) return 32;
    if (b >= 96) return b - 32;
    return b;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Turns the trace in tr into one record per write pulse.
  function automatic void analyze(input int nd, input int s, input int h);
    int all;
    all = (1 << nd) - 1;
    wrs.delete();
    for (int j = 1; j < tr.size(); j++) begin
      if (tr[j].wr != all && tr[j-1].wr == all) begin
        wr_t w;
        int  len;
        int  zeros;
        len = 0; zeros = 0;
        while (j + len < tr.size() && tr[j+len].wr == tr[j].wr) len++;
        w.disp = -1;
        for (int k = 0; k < nd; k++)
          if (((tr[j].wr >> k) & 1) == 0) begin zeros++; w.disp = k; end
        if (zeros != 1) w.disp = -1;
        w.addr = tr[j].addr; w.data = tr[j].data; w.plen = len;
        w.setup_ok = (j >= s) ? 1 : 0;
        for (int m = j - s; m < j; m++)
          if (m >= 0 && !(tr[m].wr == all && tr[m].data == w.data && tr[m].addr == w.addr))
            w.setup_ok = 0;
        w.hold_ok = (j + len + h <= tr.size()) ? 1 : 0;
        for (int m = j; m < j + len + h && m < tr.size(); m++)
          if (!(tr[m].data == w.data && tr[m].addr == w.addr) || (m >= j + len && tr[m].wr != all))
            w.hold_ok = 0;
        wrs.push_back(w);
      end
    end
  endfunction

  function automatic int n_reads(output int maxra);
    int n;
    n = 0; maxra = 0;
    foreach (tr[i]) if (tr[i].re != 0) begin
      n++;
      if (tr[i].ra > maxra) maxra = tr[i].ra;
    end
    return n;
  endfunction

  task automatic check_writes(input string tag, input int which, input int n, input int p);
    check({tag, " write count"}, wrs.size(), n);
    for (int i = 0; i < n && i < wrs.size(); i++) begin
      int b;
      b = (which != 0) ? int'(mem_b[i]) : int'(mem_a[i]);
      check($sformatf("%s[%0d] display", tag, i), wrs[i].disp, i / 4);
      check($sformatf("%s[%0d] addr", tag, i), wrs[i].addr, 3 - (i % 4));
      check($sformatf("%s[%0d] data", tag, i), wrs[i].data, ref_map(b));
      check($sformatf("%s[%0d] pulse len", tag, i), wrs[i].plen, p);
      check($sformatf("%s[%0d] setup stable", tag, i), wrs[i].setup_ok, 1);
      check($sformatf("%s[%0d] hold stable", tag, i), wrs[i].hold_ok, 1);
    end
  endtask

  function automatic bit peek(input int which, input int what);
    case (what)
      0:       return (which != 0) ? re_b : re_a;
      1:       return (which != 0) ? fd_b : fd_a;
      default: return (which != 0) ? (wr_b != 1'b1) : (wr_a != 4'hF);
    endcase
  endfunction

  function automatic bit reset_like(input int which);
    if (which != 0)
      return wr_b == 1'b1 && !re_b && ra_b == 4'd0 && d_b == 7'h20 && ad_b == 2'd0 && !fd_b;
    return wr_a == 4'hF && !re_a && ra_a == 4'd0 && d_a == 7'h20 && ad_a == 2'd0 && !fd_a;
  endfunction

  // Cycles until the event, or -1 on timeout; held reports reset-valued outputs before it.
  task automatic wait_for(input int which, input int what, input int budget,
                          output int cyc, output bit held);
    bit found;
    cyc = 0; held = 1'b1; found = 1'b0;
    while (cyc < budget && !found) begin
      @(negedge clk);
      cyc++;
      if (peek(which, what)) found = 1'b1;
      else if (!reset_like(which)) held = 1'b0;
    end
    if (!found) cyc = -1;
  endtask

  initial begin
    int         cyc, nfd, falls, nr, mra;
    bit         held;
    logic [3:0] prev;
    string      hello;

    rst_a_n = 1'b0; rst_b_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    hello = "HELLO WORLD!    ";
    for (int i = 0; i < 16; i++) mem_a[i] = hello[i];
    for (int i = 0; i < 16; i++) mem_b[i] = 8'($urandom);
    mem_b[0] = 8'h61; mem_b[1] = 8'h0A; mem_b[2] = 8'hC1; mem_b[3] = 8'h5F;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset wr_n", int'(wr_a), 15);
    check("reset read_enable", int'(re_a), 0);
    check("reset read_address", int'(ra_a), 0);
    check("reset data", int'(d_a), 32);
    check("reset addr", int'(ad_a), 0);
    check("reset frame_done", int'(fd_a), 0);
    check("reset wr_n B", int'(wr_b), 1);

    // First frame: HELLO WORLD!, first FETCH REFRESH_DIV cycles after release
    rst_a_n = 1'b1; rst_b_n = 1'b1; en_a = 1'b1;
    tr_a.delete(); rec_a = 1'b1;
    wait_for(0, 0, 400, cyc, held);
    check("first fetch latency", cyc, DIV_A);
    check("outputs held before first tick", int'(held), 1);
    wait_for(0, 1, 200, cyc, held);
    check("frame length", cyc, 96);
    @(negedge clk);
    check("frame_done single cycle", int'(fd_a), 0);
    rec_a = 1'b0; tr = tr_a; analyze(4, 1, 1);
    check_writes("hello", 0, 16, 2);
    if (wrs.size() >= 12) begin
      check("H data", wrs[0].data, 'h48);
      check("H display", wrs[0].disp, 0);
      check("H addr", wrs[0].addr, 3);
      check("! data", wrs[11].data, 'h21);
      check("! display", wrs[11].disp, 2);
      check("! addr", wrs[11].addr, 0);
    end
    nr = n_reads(mra);
    check("hello reads", nr, 16);

    // Random frame; outputs must keep the last character while idle
    for (int i = 0; i < 16; i++) mem_a[i] = 8'($urandom);
    tr_a.delete(); rec_a = 1'b1;
    wait_for(0, 0, 300, cyc, held);
    check("random frame start", int'(cyc > 0), 1);
    wait_for(0, 1, 200, cyc, held);
    check("random frame length", cyc, 96);
    rec_a = 1'b0; tr = tr_a; analyze(4, 1, 1);
    check_writes("rand", 0, 16, 2);
    repeat (20) @(negedge clk);
    check("idle data hold", int'(d_a), ref_map(int'(mem_a[15])));
    check("idle addr hold", int'(ad_a), 0);
    check("idle wr_n", int'(wr_a), 15);

    // Enable dropped during the pulse of index 5
    for (int i = 0; i < 16; i++) mem_a[i] = 8'($urandom);
    tr_a.delete(); rec_a = 1'b1;
    wait_for(0, 0, 300, cyc, held);
    check("drop frame start", int'(cyc > 0), 1);
    prev = wr_a; falls = 0; cyc = 0;
    while (falls < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (wr_a != 4'hF && prev == 4'hF) falls++;
      prev = wr_a;
    end
    check("reached pulse of index 5", falls, 6);
    en_a = 1'b0;
    nfd = 0;
    repeat (80) begin
      @(negedge clk);
      if (fd_a) nfd++;
    end
    rec_a = 1'b0; tr = tr_a; analyze(4, 1, 1);
    check_writes("drop", 0, 6, 2);
    check("drop frame_done count", nfd, 0);
    nr = n_reads(mra);
    check("drop reads", nr, 6);

    en_a = 1'b1;
    tr_a.delete(); rec_a = 1'b1;
    wait_for(0, 0, 300, cyc, held);
    check("restart fetch seen", int'(cyc > 0), 1);
    check("restart index", int'(ra_a), 0);
    wait_for(0, 1, 200, cyc, held);
    check("restart frame length", cyc, 96);
    rec_a = 1'b0; tr = tr_a; analyze(4, 1, 1);
    check_writes("restart", 0, 16, 2);

    // Reset asserted while a write pulse is low
    wait_for(0, 0, 300, cyc, held);
    wait_for(0, 2, 50, cyc, held);
    check("pulse before reset seen", int'(cyc > 0), 1);
    rst_a_n = 1'b0;
    #1;
    check("async reset wr_n", int'(wr_a), 15);
    check("async reset data", int'(d_a), 32);
    check("async reset read_enable", int'(re_a), 0);
    @(negedge clk);
    rst_a_n = 1'b1;
    wait_for(0, 0, 400, cyc, held);
    check("post-reset fetch latency", cyc, DIV_A);
    check("post-reset outputs held", int'(held), 1);

    // Single display, stretched timing
    en_b = 1'b1;
    tr_b.delete(); rec_b = 1'b1;
    wait_for(1, 0, 200, cyc, held);
    check("B frame start", int'(cyc > 0), 1);
    wait_for(1, 1, 100, cyc, held);
    check("B frame length", cyc, 4 * (2 + 2 + 3 + 2));
    @(negedge clk);
    rec_b = 1'b0; tr = tr_b; analyze(1, 2, 2);
    check_writes("B", 1, 4, 3);
    if (wrs.size() >= 4) begin
      check("map 0x61", wrs[0].data, 'h41);
      check("map 0x0A", wrs[1].data, 'h20);
      check("map 0xC1", wrs[2].data, 'h20);
      check("map 0x5F", wrs[3].data, 'h5F);
    end
    nr = n_reads(mra);
    check("B reads", nr, 4);
    check("B max read address", mra, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
